muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit downstream of the register file: consumes rd1/rd2 as
//   srca/srcb, computes MULT/MULTU/DIV/DIVU over WIDTH cycles and holds the result in HI/LO.
//   The control unit stalls on busy and reads hi/lo for MFHI/MFLO; MTHI/MTLO write via hi_we/lo_we.
// PARAMETERS
//   WIDTH  32  operand width; hi/lo are each WIDTH bits, product is 2*WIDTH
// PORTS
//   clk    in   1      single clock, all state updates on rising edge
//   reset  in   1      synchronous, active-high
//   start  in   1      request an operation; accepted only when busy==0
//   op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   srca   in   WIDTH  multiplicand / dividend (from rd1)
//   srcb   in   WIDTH  multiplier / divisor (from rd2)
//   hi_we  in   1      MTHI: hi <= wd when idle
//   lo_we  in   1      MTLO: lo <= wd when idle
//   wd     in   WIDTH  move-to data
//   busy   out  1      high while an operation is in flight (state != IDLE)
//   done   out  1      registered one-cycle pulse, first cycle new hi/lo are visible
//   hi     out  WIDTH  HI register (product upper half / remainder)
//   lo     out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//   Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Applies mid-operation:
//     the operation is abandoned and no result is written.
//   FSM IDLE -> RUN -> FIN -> IDLE.
//   - IDLE: at edge E0 with start=1: latch op, |srca|, |srcb| (absolute values only for signed ops),
//     sign flags; count=0; -> RUN. Otherwise stay.
//   - RUN: one iteration per edge (shift-add multiply / restoring divide, one bit per edge);
//     count++; at the edge where count==WIDTH-1 -> FIN. RUN occupies edges E1..E_WIDTH.
//   - FIN: edge E_(WIDTH+1): apply sign correction, write hi/lo, set done=1, -> IDLE.
//   Latency: result visible and done=1 in the cycle after E_(WIDTH+1) (33 edges for WIDTH=32).
//   busy is combinational from the state: 0 in E0's cycle, 1 from after E0 until after E_(WIDTH+1).
//   done stays high for exactly one cycle, even if a new start is accepted in that cycle.
//   Signed multiply: negate the 2*WIDTH product iff sign(srca)!=sign(srcb). No overflow.
//   Signed divide: negate the quotient iff signs differ; the remainder takes the dividend's sign.
//   DIV of most-negative value by -1: lo=0x80000000, hi=0 (wraps, no trap).
//   Divide by zero (DIV/DIVU): lo = all ones, hi = original srca; same latency as any divide.
//   start while busy: ignored, no queueing. The caller must hold start until busy is seen.
//   hi_we/lo_we while busy: ignored. hi_we/lo_we in IDLE: write at that edge, and may coincide
//     with start (the move lands now; the operation overwrites at FIN).
//   hi/lo are unchanged except at FIN, reset or an accepted move-to.
// TESTING
//   1 MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 edges done=1, hi=0xFFFFFFFE, lo=0x00000001; busy 1 for 33 cycles
//   2 MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0
//   3 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000/-1 -> lo=0x80000000, hi=0
//   4 DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234, done after 33 edges
//   5 start pulsed and hi_we=1 mid-RUN -> both ignored, first result intact; idle hi_we wd=0xA5 -> hi=0xA5 next cycle
//   6 reset asserted at edge 10 of a MULTU -> busy=0, done=0, hi=lo=0; no done pulse follows

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per clock,
// with sign handling around an unsigned core and HI/LO result registers.
//
// state | meaning
// IDLE  | waiting for start; move-to writes accepted
// RUN   | one multiply/divide iteration per edge
// FIN   | sign correction, hi/lo write, done pulse
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        p_d       = p_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        sign_a = ~op[0] & srca[WIDTH-1];
        sign_b = ~op[0] & srcb[WIDTH-1];
        abs_a  = sign_a ? -srca : srca;
        abs_b  = sign_b ? -srcb : srcb;

        // p holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_sub   = div_shift[WIDTH-1:0] - opnd_q;

        prod = neg_res_q ? -p_q : p_q;
        quo  = (neg_res_q && opnd_q != '0) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        rem  = neg_rem_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

        unique case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wd;
                if (lo_we) lo_d = wd;
                if (start) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    is_div_d  = op[1];
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    opnd_d    = op[1] ? abs_b : abs_a;
                    p_d       = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    if (div_ge) p_d = {div_sub, p_q[WIDTH-2:0], 1'b1};
                    else        p_d = {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
                end else begin
                    p_d = {mul_sum, p_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                // divide by zero falls out of the restoring loop as q=all ones, r=|a|;
                // only the quotient sign flip has to be suppressed
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            p_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            p_q       <= p_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
